// File: rtl/uart_pkg.sv
// Shared types and helpers for the buffered UART blocks.
package uart_pkg;

    typedef enum logic [1:0] {
        PAR_NONE = 2'd0,
        PAR_ODD  = 2'd1,
        PAR_EVEN = 2'd2
    } parity_t;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_START,
        ST_DATA,
        ST_PARITY,
        ST_STOP
    } tx_state_t;

    function automatic int cycles_per_bit(input int clk_hz, input int baud);
        return clk_hz / baud;
    endfunction

endpackage

// File: rtl/sync_fifo.sv
// Single-clock FIFO with occupancy count; the extra count bit separates full from empty.
module sync_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 16
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     push,
    input  logic [WIDTH-1:0]         wr_data,
    input  logic                     pop,
    output logic [WIDTH-1:0]         rd_data,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic             do_push;
    logic             do_pop;

    // A push while full is refused even if a pop happens on the same edge.
    assign full    = (count == FULL_CNT);
    assign empty   = (count == '0);
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;
    assign rd_data = mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
            case ({do_push, do_pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr] <= wr_data;
    end

endmodule

// File: rtl/uart_tx_buffered.sv
// FIFO-buffered UART transmitter: queued bytes are framed and sent back-to-back.
module uart_tx_buffered
    import uart_pkg::*;
#(
    parameter int CLK_HZ     = 100_000_000,
    parameter int BAUD       = 115200,
    parameter int DATA_BITS  = 8,
    parameter int PARITY     = 0,
    parameter int STOP_BITS  = 1,
    parameter int FIFO_DEPTH = 16
) (
    input  logic                          clk_in,
    input  logic                          rst_in,
    input  logic                          valid_in,
    input  logic [DATA_BITS-1:0]          data_in,
    output logic                          ready_out,
    output logic                          uart_txd_out,
    output logic                          busy_out,
    output logic [$clog2(FIFO_DEPTH):0]   fill_out,
    output logic                          overflow_out
);

    localparam int CPB   = cycles_per_bit(CLK_HZ, BAUD);
    localparam int CNT_W = (CPB > 1) ? $clog2(CPB) : 1;
    localparam int IDX_W = 4;

    if (CPB < 2) begin : g_bad_cpb
        $error("uart_tx_buffered: CLK_HZ/BAUD must be at least 2");
    end
    if (DATA_BITS < 5 || DATA_BITS > 9) begin : g_bad_data_bits
        $error("uart_tx_buffered: DATA_BITS must be 5..9");
    end
    if (PARITY < 0 || PARITY > 2) begin : g_bad_parity
        $error("uart_tx_buffered: PARITY must be 0, 1 or 2");
    end
    if (STOP_BITS < 1 || STOP_BITS > 2) begin : g_bad_stop
        $error("uart_tx_buffered: STOP_BITS must be 1 or 2");
    end
    if (FIFO_DEPTH < 2 || (FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0) begin : g_bad_depth
        $error("uart_tx_buffered: FIFO_DEPTH must be a power of two >= 2");
    end

    tx_state_t            state;
    tx_state_t            state_next;
    logic [CNT_W-1:0]     baud_cnt;
    logic [IDX_W-1:0]     bit_idx;
    logic [DATA_BITS-1:0] shift;
    logic                 par_acc;
    logic                 txd;
    logic                 line_next;
    logic                 bit_done;
    logic                 pop;
    logic                 shift_en;
    logic                 idx_clr;
    logic                 idx_inc;
    logic                 overflow;
    logic [DATA_BITS-1:0] fifo_head;
    logic                 fifo_full;
    logic                 fifo_empty;

    function automatic logic parity_bit(input logic ones_xor);
        return (PARITY == int'(PAR_ODD)) ? ~ones_xor : ones_xor;
    endfunction

    sync_fifo #(
        .WIDTH (DATA_BITS),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk     (clk_in),
        .rst     (rst_in),
        .push    (valid_in),
        .wr_data (data_in),
        .pop     (pop),
        .rd_data (fifo_head),
        .full    (fifo_full),
        .empty   (fifo_empty),
        .count   (fill_out)
    );

    assign bit_done     = (baud_cnt == CNT_W'(CPB - 1));
    assign ready_out    = !fifo_full;
    assign busy_out     = (state != ST_IDLE);
    assign uart_txd_out = txd;
    assign overflow_out = overflow;

    // The line level is computed for the state being entered so it registers on the same edge.
    always_comb begin
        state_next = state;
        line_next  = txd;
        pop        = 1'b0;
        shift_en   = 1'b0;
        idx_clr    = 1'b0;
        idx_inc    = 1'b0;
        case (state)
            ST_IDLE: begin
                line_next = 1'b1;
                if (!fifo_empty) begin
                    state_next = ST_START;
                    pop        = 1'b1;
                    line_next  = 1'b0;
                end
            end
            ST_START: begin
                if (bit_done) begin
                    state_next = ST_DATA;
                    line_next  = shift[0];
                    idx_clr    = 1'b1;
                end
            end
            ST_DATA: begin
                if (bit_done) begin
                    shift_en = 1'b1;
                    if (bit_idx == IDX_W'(DATA_BITS - 1)) begin
                        idx_clr = 1'b1;
                        if (PARITY == 0) begin
                            state_next = ST_STOP;
                            line_next  = 1'b1;
                        end else begin
                            state_next = ST_PARITY;
                            line_next  = parity_bit(par_acc ^ shift[0]);
                        end
                    end else begin
                        idx_inc   = 1'b1;
                        line_next = shift[1];
                    end
                end
            end
            ST_PARITY: begin
                if (bit_done) begin
                    state_next = ST_STOP;
                    line_next  = 1'b1;
                    idx_clr    = 1'b1;
                end
            end
            ST_STOP: begin
                if (bit_done) begin
                    if (bit_idx == IDX_W'(STOP_BITS - 1)) begin
                        idx_clr = 1'b1;
                        if (!fifo_empty) begin
                            state_next = ST_START;
                            pop        = 1'b1;
                            line_next  = 1'b0;
                        end else begin
                            state_next = ST_IDLE;
                            line_next  = 1'b1;
                        end
                    end else begin
                        idx_inc   = 1'b1;
                        line_next = 1'b1;
                    end
                end
            end
            default: begin
                state_next = ST_IDLE;
                line_next  = 1'b1;
            end
        endcase
    end

    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            state    <= ST_IDLE;
            txd      <= 1'b1;
            baud_cnt <= '0;
            bit_idx  <= '0;
            overflow <= 1'b0;
        end else begin
            state <= state_next;
            txd   <= line_next;
            if (state == ST_IDLE || bit_done) baud_cnt <= '0;
            else                              baud_cnt <= baud_cnt + 1'b1;
            if (idx_clr)      bit_idx <= '0;
            else if (idx_inc) bit_idx <= bit_idx + 1'b1;
            if (valid_in && !ready_out) overflow <= 1'b1;
        end
    end

    // Parity accumulates the bits already sent; it restarts on every load.
    always_ff @(posedge clk_in) begin
        if (pop) begin
            shift   <= fifo_head;
            par_acc <= 1'b0;
        end else if (shift_en) begin
            shift   <= shift >> 1;
            par_acc <= par_acc ^ shift[0];
        end
    end

endmodule

// File: tb/tb_uart_tx_buffered.sv
// Directed bench for uart_tx_buffered: default 8N1 frame, 7E2 frame, burst, overflow, push/pop and reset.
module tb_uart_tx_buffered;

    localparam int DEF_CPB  = 868;
    localparam int FAST_CPB = 16;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst;
    logic       valid_a, valid_b, valid_c;
    logic [7:0] data_a, data_b;
    logic [6:0] data_c;
    logic       ready_a, ready_b, ready_c;
    logic       txd_a, txd_b, txd_c;
    logic       busy_a, busy_b, busy_c;
    logic       ovf_a, ovf_b, ovf_c;
    logic [4:0] fill_a, fill_b, fill_c;

    uart_tx_buffered dut_a (
        .clk_in(clk), .rst_in(rst), .valid_in(valid_a), .data_in(data_a),
        .ready_out(ready_a), .uart_txd_out(txd_a), .busy_out(busy_a),
        .fill_out(fill_a), .overflow_out(ovf_a)
    );

    uart_tx_buffered #(.CLK_HZ(160), .BAUD(10)) dut_b (
        .clk_in(clk), .rst_in(rst), .valid_in(valid_b), .data_in(data_b),
        .ready_out(ready_b), .uart_txd_out(txd_b), .busy_out(busy_b),
        .fill_out(fill_b), .overflow_out(ovf_b)
    );

    uart_tx_buffered #(.CLK_HZ(160), .BAUD(10), .DATA_BITS(7), .PARITY(2), .STOP_BITS(2)) dut_c (
        .clk_in(clk), .rst_in(rst), .valid_in(valid_c), .data_in(data_c),
        .ready_out(ready_c), .uart_txd_out(txd_c), .busy_out(busy_c),
        .fill_out(fill_c), .overflow_out(ovf_c)
    );

    int   n_checks = 0;
    int   n_fail   = 0;
    int   busy_cycles;
    int   sel = 0;
    logic line, busy;

    always_comb begin
        line = 1'b1;
        busy = 1'b0;
        case (sel)
            0: begin line = txd_a; busy = busy_a; end
            1: begin line = txd_b; busy = busy_b; end
            2: begin line = txd_c; busy = busy_c; end
            default: begin line = 1'b1; busy = 1'b0; end
        endcase
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Starts on the first cycle of the start bit; checks the first and last cycle of every bit.
    task automatic check_frame(input logic [15:0] bits, input int nbits, input int cpb, input string tag);
        busy_cycles = 0;
        for (int k = 0; k < nbits; k++) begin
            check($sformatf("%s_bit%0d_first", tag, k), 32'(line), 32'(bits[k]));
            for (int c = 0; c < cpb; c++) begin
                if (busy === 1'b1) busy_cycles++;
                if (c == cpb - 1)
                    check($sformatf("%s_bit%0d_last", tag, k), 32'(line), 32'(bits[k]));
                @(negedge clk);
            end
        end
    endtask

    // Line monitor on dut_b: records byte, start-bit cycle and stop level of each frame.
    int         cyc = 0;
    logic       mon_en = 1'b0;
    logic [7:0] rx_q[$];
    int         rx_t[$];
    logic       rx_stop[$];

    always @(posedge clk) cyc <= cyc + 1;

    initial begin : monitor
        logic [7:0] b;
        int         t;
        forever begin
            @(negedge clk);
            if (mon_en && txd_b === 1'b0) begin
                t = cyc;
                repeat (FAST_CPB / 2) @(negedge clk);
                for (int i = 0; i < 8; i++) begin
                    repeat (FAST_CPB) @(negedge clk);
                    b[i] = txd_b;
                end
                repeat (FAST_CPB) @(negedge clk);
                rx_q.push_back(b);
                rx_t.push_back(t);
                rx_stop.push_back(txd_b);
            end
        end
    end

    initial begin
        int   n, guard, peak, bad;
        logic acc;
        logic [7:0] exp_b;

        rst = 1'b1;
        valid_a = 1'b0; valid_b = 1'b0; valid_c = 1'b0;
        data_a = '0; data_b = '0; data_c = '0;
        repeat (3) @(negedge clk);
        rst = 1'b0;

        check("rst_txd_a",  32'(txd_a),   1);
        check("rst_busy_a", 32'(busy_a),  0);
        check("rst_ready_a", 32'(ready_a), 1);
        check("rst_fill_a", 32'(fill_a),  0);
        check("rst_ovf_a",  32'(ovf_a),   0);
        check("rst_txd_b",  32'(txd_b),   1);
        check("rst_fill_b", 32'(fill_b),  0);
        check("rst_ready_b", 32'(ready_b), 1);
        check("rst_ready_c", 32'(ready_c), 1);
        check("rst_fill_c", 32'(fill_c),  0);
        check("rst_ovf_c",  32'(ovf_c),   0);

        // Default parameters, single byte 0xA5
        sel = 0;
        valid_a = 1'b1; data_a = 8'hA5;
        @(negedge clk);
        valid_a = 1'b0;
        check("a_fill_after_push", 32'(fill_a), 1);
        check("a_idle_before_start", 32'(busy_a), 0);
        check("a_line_before_start", 32'(txd_a), 1);
        @(negedge clk);
        check("a_busy_rise", 32'(busy_a), 1);
        check("a_fill_after_pop", 32'(fill_a), 0);
        check_frame({6'b0, 1'b1, 8'hA5, 1'b0}, 10, DEF_CPB, "a_frame");
        check("a_busy_cycles", busy_cycles, 10 * DEF_CPB);
        check("a_busy_fall", 32'(busy_a), 0);
        check("a_line_idle", 32'(txd_a), 1);
        check("a_fill_end", 32'(fill_a), 0);

        // 7 data bits, even parity, two stops, byte 0x07
        sel = 2;
        valid_c = 1'b1; data_c = 7'h07;
        @(negedge clk);
        valid_c = 1'b0;
        @(negedge clk);
        check("c_busy_rise", 32'(busy_c), 1);
        check_frame({5'b0, 2'b11, 1'b1, 7'h07, 1'b0}, 11, FAST_CPB, "c_frame");
        check("c_busy_cycles", busy_cycles, 11 * FAST_CPB);
        check("c_busy_fall", 32'(busy_c), 0);

        // Burst of 17 writes with valid held high
        sel = 1;
        mon_en = 1'b1;
        valid_b = 1'b1; data_b = 8'h10;
        n = 0; guard = 0; peak = 0;
        while (n < 17 && guard < 40) begin
            acc = ready_b;
            @(negedge clk);
            guard++;
            if (acc) begin
                n++;
                data_b = 8'h10 + 8'(n);
            end
            if (int'(fill_b) > peak) peak = int'(fill_b);
        end
        check("b_burst_accepted", n, 17);
        check("b_burst_cycles", guard, 17);
        check("b_fill_peak", peak, 16);
        check("b_ready_full", 32'(ready_b), 0);
        check("b_busy_burst", 32'(busy_b), 1);

        // Writes while full are dropped
        data_b = 8'hEE;
        repeat (4) @(negedge clk);
        valid_b = 1'b0;
        check("b_fill_still_full", 32'(fill_b), 16);
        check("b_overflow_set", 32'(ovf_b), 1);
        check("b_ready_still_low", 32'(ready_b), 0);

        // Push on the STOP->START pop edge while four bytes are queued
        guard = 0;
        while (fill_b !== 5'd4 && guard < 3000) begin
            @(negedge clk);
            guard++;
        end
        check("b_fill_reach4", 32'(fill_b), 4);
        repeat (FAST_CPB * 10 - 1) @(negedge clk);
        check("b_fill_before_pushpop", 32'(fill_b), 4);
        check("b_stop_before_pushpop", 32'(txd_b), 1);
        valid_b = 1'b1; data_b = 8'h55;
        @(negedge clk);
        valid_b = 1'b0;
        check("b_fill_pushpop", 32'(fill_b), 4);
        check("b_start_on_pushpop", 32'(txd_b), 0);

        guard = 0;
        while (busy_b !== 1'b0 && guard < 4000) begin
            @(negedge clk);
            guard++;
        end
        check("b_drained", 32'(busy_b), 0);
        check("b_fill_drained", 32'(fill_b), 0);
        repeat (2) @(negedge clk);
        mon_en = 1'b0;

        check("b_rx_count", rx_q.size(), 18);
        for (int i = 0; i < 18 && i < rx_q.size(); i++) begin
            exp_b = (i < 17) ? 8'h10 + 8'(i) : 8'h55;
            check($sformatf("b_rx_byte%0d", i), 32'(rx_q[i]), 32'(exp_b));
            check($sformatf("b_rx_stop%0d", i), 32'(rx_stop[i]), 1);
            if (i > 0)
                check($sformatf("b_rx_gap%0d", i), rx_t[i] - rx_t[i-1], 10 * FAST_CPB);
        end
        check("b_overflow_sticky", 32'(ovf_b), 1);

        // Reset mid data bit with three bytes queued
        valid_b = 1'b1;
        for (int i = 0; i < 4; i++) begin
            data_b = 8'h30 + 8'(2 * i);
            @(negedge clk);
        end
        valid_b = 1'b0;
        repeat (20) @(negedge clk);
        check("r_fill_queued", 32'(fill_b), 3);
        check("r_busy_mid", 32'(busy_b), 1);
        check("r_line_mid_data", 32'(txd_b), 0);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check("r_txd", 32'(txd_b), 1);
        check("r_fill", 32'(fill_b), 0);
        check("r_busy", 32'(busy_b), 0);
        check("r_ready", 32'(ready_b), 1);
        check("r_overflow_clear", 32'(ovf_b), 0);
        bad = 0;
        for (int i = 0; i < 400; i++) begin
            @(negedge clk);
            if (txd_b !== 1'b1 || busy_b !== 1'b0) bad++;
        end
        check("r_no_more_frames", bad, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
